// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 command transmitter.
//
// Sends one command byte (for example 0xED set-LEDs or 0xFF reset) to a
// keyboard. It shares the kbd_clk/kbd_dat lines with the receive path and
// drives them only through open-drain pull-low enables.
//
// Sequence:
//   1. Inhibit: hold clock low.
//   2. Request-to-send: pull data low.
//   3. Release the clock.
//   4. Shift data/parity/stop on device clock falls.
//   5. Sample the device ACK.
//   6. Wait for the bus to go idle.
//
// Ports:
//   clk, resetN        system clock, asynchronous active-low reset
//   din, din_valid     command byte and start request (accepted only when idle)
//   busy               high whenever a transaction is in progress
//   done               one-cycle pulse at the end of every transaction
//   ack_ok             1 = device acknowledged the last transaction
//   error              one-cycle pulse on timeout, coincident with done
//   kbd_clk, kbd_dat   raw pad inputs of the PS/2 lines
//   kbd_*_drive_low    registered pull-low enables for the pads
`timescale 1ns/1ps

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error,
  input  logic       kbd_clk,
  input  logic       kbd_dat,
  output logic       kbd_clk_drive_low,
  output logic       kbd_dat_drive_low
);

  localparam int CNT_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_TX, S_ACK, S_RELEASE, S_DONE, S_TOUT
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [TMR_W-1:0] timer;
  logic [3:0]       bitcnt;
  logic [9:0]       shift;       // {stop, parity, data}; bit 0 goes out next
  logic             clk_meta, clk_sync, clk_prev;
  logic             dat_meta, dat_sync;
  logic             fall;
  logic             timeout_hit;
  logic             clk_drive_d, dat_drive_d;

  // Two-flop synchronizers. They reset to 1 (idle bus), so that leaving
  // reset cannot look like a clock fall.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      clk_prev <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= kbd_clk;
      clk_sync <= clk_meta;
      clk_prev <= clk_sync;
      dat_meta <= kbd_dat;
      dat_sync <= dat_meta;
    end
  end

  assign fall = clk_prev & ~clk_sync;

  // The 15 ms budget covers everything from clock release to bus idle.
  assign timeout_hit = (state == S_TX || state == S_ACK || state == S_RELEASE) &&
                       (timer == TMR_W'(TIMEOUT_CYCLES - 1));

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state logic. A timeout is tested before any clock fall, so it wins.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (din_valid) state_next = S_INHIBIT;
      S_INHIBIT: if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) state_next = S_REQ;
      S_REQ:     state_next = S_TX;
      S_TX: begin
        if (timeout_hit)               state_next = S_TOUT;
        else if (fall && bitcnt == 4'd9) state_next = S_ACK;
      end
      S_ACK: begin
        if (timeout_hit) state_next = S_TOUT;
        else if (fall)   state_next = S_RELEASE;
      end
      S_RELEASE: begin
        if (timeout_hit)               state_next = S_TOUT;
        else if (clk_sync && dat_sync) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      S_TOUT:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Pad drive values for the coming state; they are registered below, so
  // the pads never see a combinational path from the inputs.
  // In TX the data drive holds its value between falls. It keeps the
  // start bit from REQ until the first fall, and updates only on falls.
  always_comb begin
    clk_drive_d = 1'b0;
    dat_drive_d = 1'b0;
    case (state_next)
      S_INHIBIT: clk_drive_d = 1'b1;
      S_REQ: begin
        clk_drive_d = 1'b1;
        dat_drive_d = 1'b1;
      end
      S_TX: dat_drive_d = (state == S_TX && fall) ? ~shift[0] : kbd_dat_drive_low;
      default: ;
    endcase
  end

  // Moore status outputs decoded straight from the state register
  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE) || (state == S_TOUT);
  assign error = (state == S_TOUT);

  // Datapath: counters, frame shifter, result flag and pad drive registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt               <= '0;
      timer             <= '0;
      bitcnt            <= '0;
      shift             <= '0;
      ack_ok            <= 1'b0;
      kbd_clk_drive_low <= 1'b0;
      kbd_dat_drive_low <= 1'b0;
    end else begin
      kbd_clk_drive_low <= clk_drive_d;
      kbd_dat_drive_low <= dat_drive_d;
      case (state)
        S_IDLE: if (din_valid) begin
          shift  <= {1'b1, ~^din, din};   // stop, odd parity, data
          ack_ok <= 1'b0;
          cnt    <= '0;
        end
        S_INHIBIT: cnt <= cnt + 1'b1;
        S_REQ: begin
          bitcnt <= '0;
          timer  <= '0;
        end
        S_TX: begin
          timer <= timer + 1'b1;
          if (fall && !timeout_hit) begin
            shift  <= {1'b0, shift[9:1]};
            bitcnt <= bitcnt + 1'b1;
          end
        end
        S_ACK: begin
          timer <= timer + 1'b1;
          if (fall && !timeout_hit) ack_ok <= ~dat_sync;
        end
        S_RELEASE: timer <= timer + 1'b1;
        default: ;
      endcase
      if (timeout_hit) ack_ok <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx -- self-checking bench for ps2_host_tx.
//
// A behavioural keyboard model runs on the wired-AND bus. It waits for the
// host's request-to-send, then generates 11 clock pulses (20 cycles low,
// 20 cycles high). It samples the line in the high phase before each fall,
// and pulls data low before the 11th fall when it is told to ACK.
//
// The expected frame is built arithmetically from the byte: start 0, data
// LSB first, then odd parity (found by counting ones), then stop 1.
`timescale 1ns/1ps

module tb_ps2_host_tx;

  localparam int INH = 10;
  localparam int TMO = 4000;

  logic       clk = 1'b0;
  logic       resetN;
  logic [7:0] din;
  logic       din_valid;
  logic       busy, done, ack_ok, error;
  logic       clk_drv, dat_drv;
  logic       dev_clk_low, dev_dat_low;
  logic       kbd_clk_w, kbd_dat_w;

  int n_pass = 0;
  int n_total = 0;
  int done_total = 0;
  int clkdrv_total = 0;

  typedef struct {
    logic [7:0] b;
    bit         dev_ack;
    logic       exp_ack_ok;
    logic       exp_parity;
  } vec_t;

  vec_t vecs[5];

  // Open-drain bus: either side may pull a line low
  assign kbd_clk_w = ~(clk_drv | dev_clk_low);
  assign kbd_dat_w = ~(dat_drv | dev_dat_low);

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk               (clk),
    .resetN            (resetN),
    .din               (din),
    .din_valid         (din_valid),
    .busy              (busy),
    .done              (done),
    .ack_ok            (ack_ok),
    .error             (error),
    .kbd_clk           (kbd_clk_w),
    .kbd_dat           (kbd_dat_w),
    .kbd_clk_drive_low (clk_drv),
    .kbd_dat_drive_low (dat_drv)
  );

  // Running totals of done pulses and clock-drive cycles, sampled away from posedge
  always @(negedge clk) begin
    if (done === 1'b1)    done_total   <= done_total + 1;
    if (clk_drv === 1'b1) clkdrv_total <= clkdrv_total + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else             n_pass++;
  endtask

  function automatic logic [10:0] expected_frame(input logic [7:0] b);
    int ones;
    logic [10:0] f;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    f[0]   = 1'b0;
    f[8:1] = b;
    f[9]   = (ones % 2 == 0);
    f[10]  = 1'b1;
    return f;
  endfunction

  // Keyboard model
  task automatic device(input bit give_ack, output logic [10:0] bits);
    bit req;
    req  = 0;
    bits = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (clk_drv === 1'b0 && dat_drv === 1'b1) begin
        req = 1;
        break;
      end
    end
    if (!req) return;
    for (int i = 0; i < 11; i++) begin
      repeat (10) @(negedge clk);
      bits[i] = kbd_dat_w;
      if (i == 10 && give_ack) dev_dat_low = 1'b1;
      repeat (10) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b0;
    end
    repeat (5) @(negedge clk);
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit got, output logic a, output logic e);
    got = 0;
    a   = 1'b0;
    e   = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1;
        a   = ack_ok;
        e   = error;
        break;
      end
    end
  endtask

  task automatic start(input logic [7:0] b);
    @(negedge clk);
    din       = b;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    din       = ~b;   // must not disturb the transaction already accepted
  endtask

  task automatic run_txn(input logic [7:0] b, input bit dev_ack, input logic exp_ack,
                         output logic [10:0] bits);
    bit   got;
    logic a, e;
    int   d0, c0;
    d0 = done_total;
    c0 = clkdrv_total;
    start(b);
    fork
      device(dev_ack, bits);
      wait_done(3000, got, a, e);
    join
    check("done_seen", 32'(got), 32'd1);
    check("frame", 32'(bits), 32'(expected_frame(b)));
    check("ack_ok", 32'(a), 32'(exp_ack));
    check("error", 32'(e), 32'd0);
    @(negedge clk);
    check("busy_after", 32'(busy), 32'd0);
    check("done_pulses", 32'(done_total - d0), 32'd1);
    check("clk_drive_cycles", 32'(clkdrv_total - c0), 32'd11);
  endtask

  initial begin
    logic [10:0] bits;
    bit          got;
    logic        a, e;
    int          d0, cyc;

    vecs[0] = '{b: 8'hED, dev_ack: 1'b1, exp_ack_ok: 1'b1, exp_parity: 1'b1};
    vecs[1] = '{b: 8'h01, dev_ack: 1'b1, exp_ack_ok: 1'b1, exp_parity: 1'b0};
    vecs[2] = '{b: 8'h00, dev_ack: 1'b1, exp_ack_ok: 1'b1, exp_parity: 1'b1};
    vecs[3] = '{b: 8'hED, dev_ack: 1'b0, exp_ack_ok: 1'b0, exp_parity: 1'b1};
    vecs[4] = '{b: 8'hF4, dev_ack: 1'b1, exp_ack_ok: 1'b1, exp_parity: 1'b0};

    resetN      = 1'b0;
    din         = 8'h00;
    din_valid   = 1'b0;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({busy, done, ack_ok, error, clk_drv, dat_drv}), 32'd0);
    resetN = 1'b1;
    repeat (3) @(negedge clk);

    // Table-driven transactions
    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i].b, vecs[i].dev_ack, vecs[i].exp_ack_ok, bits);
      check("parity_bit", 32'(bits[9]), 32'(vecs[i].exp_parity));
      repeat (5) @(negedge clk);
    end

    // Random bytes, random ACK/NACK
    for (int r = 0; r < 6; r++) begin
      logic [7:0] rb;
      bit         rk;
      rb = 8'($urandom_range(0, 255));
      rk = 1'($urandom_range(0, 1));
      run_txn(rb, rk, rk, bits);
      repeat (5) @(negedge clk);
    end

    // din_valid pulsed with 0x55 while busy: ignored
    d0 = done_total;
    start(8'hED);
    fork
      device(1'b1, bits);
      wait_done(3000, got, a, e);
      for (int k = 0; k < 10; k++) begin
        repeat (30) @(negedge clk);
        if (!busy) break;
        din       = 8'h55;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
      end
    join
    check("busy_req_frame", 32'(bits), 32'(expected_frame(8'hED)));
    check("busy_req_ack", 32'(a), 32'd1);
    repeat (50) @(negedge clk);
    check("busy_req_done_pulses", 32'(done_total - d0), 32'd1);
    check("busy_req_idle", 32'(busy), 32'd0);

    // Device never clocks: timeout exactly TMO cycles after clock release
    d0 = done_total;
    start(8'hFF);
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (clk_drv === 1'b0 && dat_drv === 1'b1) begin
        got = 1;
        break;
      end
    end
    check("tmo_request_seen", 32'(got), 32'd1);
    cyc = 0;
    got = 0;
    for (int i = 0; i < TMO + 200; i++) begin
      @(negedge clk);
      cyc++;
      if (error === 1'b1) begin
        got = 1;
        break;
      end
    end
    check("tmo_error_seen", 32'(got), 32'd1);
    check("tmo_latency", 32'(cyc), 32'(TMO));
    check("tmo_done_with_error", 32'(done), 32'd1);
    check("tmo_drives", 32'({clk_drv, dat_drv}), 32'd0);
    check("tmo_ack_ok", 32'(ack_ok), 32'd0);
    @(negedge clk);
    check("tmo_idle", 32'({busy, done, error}), 32'd0);
    check("tmo_done_pulses", 32'(done_total - d0), 32'd1);

    // Reset during the 5th data bit
    d0 = done_total;
    start(8'hED);
    fork
      device(1'b1, bits);
      begin
        got = 0;
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (clk_drv === 1'b0 && dat_drv === 1'b1) begin
            got = 1;
            break;
          end
        end
        repeat (200) @(negedge clk);
        resetN = 1'b0;
        #1;
        check("rst_drives", 32'({clk_drv, dat_drv}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        resetN = 1'b1;
      end
    join
    check("rst_request_seen", 32'(got), 32'd1);
    repeat (20) @(negedge clk);
    check("rst_no_done", 32'(done_total - d0), 32'd0);
    run_txn(8'hF4, 1'b1, 1'b1, bits);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
